// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } state_t;

    localparam int DEF_NUM_SETS       = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_W         = 32;

    localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(DEF_NUM_SETS);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;

    // Helpers take the field widths explicitly so a re-parameterised cache can reuse them.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int offset_w);
        return (addr >> 2) & ((64'd1 << offset_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int offset_w,
                                               input int index_w);
        return (addr >> (2 + offset_w)) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int offset_w,
                                             input int index_w);
        return addr >> (2 + offset_w + index_w);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational lookup, synchronous word and tag writes,
// valid bits cleared on reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_SETS       = DEF_NUM_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int IDX_BITS       = INDEX_W,
    parameter int OFF_BITS       = OFFSET_W,
    parameter int TAG_BITS       = TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_index,
    input  logic [OFF_BITS-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                word_we,
    input  logic [IDX_BITS-1:0] wr_index,
    input  logic [OFF_BITS-1:0] wr_offset,
    input  logic [31:0]         wr_data,
    input  logic                tag_we,
    input  logic [TAG_BITS-1:0] wr_tag
);

    logic [NUM_SETS-1:0] valid_vec;
    logic [TAG_BITS-1:0] tag_mem  [NUM_SETS];
    logic [31:0]         data_mem [NUM_SETS*WORDS_PER_LINE];

    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
            logic valid_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else if (tag_we && wr_index == IDX_BITS'(gi)) begin
                    valid_reg <= 1'b1;
                end
            end
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (word_we) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_vec[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with a blocking word-by-word refill.
// Define ICACHE_STATS_EN to add the o_hit_cnt / o_miss_cnt counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_SETS       = DEF_NUM_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_ren,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic [31:0]       o_res_rdata,
    output logic              o_res_valid,
    output logic              o_busy,
    output logic              o_mem_ren,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ready,
    input  logic              i_mem_valid,
    input  logic [31:0]       i_mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       o_hit_cnt,
    output logic [31:0]       o_miss_cnt
`endif
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;
    localparam int LINE_W   = ADDR_W - OFF_BITS - 2;

    state_t              state_reg, state_next;
    logic [OFF_BITS-1:0] count_reg, count_next;
    logic [LINE_W-1:0]   line_reg, line_next;

    logic [OFF_BITS-1:0] req_offset;
    logic [IDX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0] req_tag;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;
    logic                hit;
    logic                word_we;
    logic                tag_we;

    assign req_offset = OFF_BITS'(addr_offset(64'(i_req_addr), OFF_BITS));
    assign req_index  = IDX_BITS'(addr_index(64'(i_req_addr), OFF_BITS, IDX_BITS));
    assign req_tag    = TAG_BITS'(addr_tag(64'(i_req_addr), OFF_BITS, IDX_BITS));
    assign hit        = i_req_ren && rd_valid && (rd_tag == req_tag);

    icache_array #(
        .NUM_SETS       (NUM_SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_BITS       (IDX_BITS),
        .OFF_BITS       (OFF_BITS),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .rd_index  (req_index),
        .rd_offset (req_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .wr_index  (line_reg[IDX_BITS-1:0]),
        .wr_offset (count_reg),
        .wr_data   (i_mem_rdata),
        .tag_we    (tag_we),
        .wr_tag    (line_reg[LINE_W-1:IDX_BITS])
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        line_next   = line_reg;
        o_res_valid = 1'b0;
        o_res_rdata = '0;
        o_busy      = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_addr  = '0;
        word_we     = 1'b0;
        tag_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    o_res_valid = 1'b1;
                    o_res_rdata = rd_data;
                end else if (i_req_ren) begin
                    o_busy     = 1'b1;
                    line_next  = i_req_addr[ADDR_W-1:OFF_BITS+2];
                    count_next = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                o_busy     = 1'b1;
                o_mem_ren  = 1'b1;
                o_mem_addr = {line_reg, count_reg, 2'b00};
                if (i_mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Data seen in REQ (same cycle as the accept) never reaches here.
                o_busy = 1'b1;
                if (i_mem_valid) begin
                    word_we = 1'b1;
                    if (count_reg == OFF_BITS'(WORDS_PER_LINE - 1)) begin
                        state_next = FILL;
                    end else begin
                        count_next = count_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            FILL: begin
                o_busy     = 1'b1;
                tag_we     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs stay quiet while reset is asserted, whatever the fetch stage drives.
        if (!i_rst_n) begin
            o_res_valid = 1'b0;
            o_res_rdata = '0;
            o_busy      = 1'b0;
            o_mem_ren   = 1'b0;
            o_mem_addr  = '0;
            word_we     = 1'b0;
            tag_we      = 1'b0;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;
    logic        miss_start;

    assign miss_start = (state_reg == IDLE) && i_req_ren && !hit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (o_res_valid) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = hit_cnt_reg;
    assign o_miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, hit, conflict eviction, memory
// backpressure, reset during refill and (with ICACHE_STATS_EN) the counters.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_ren;
    logic [31:0] req_addr;
    logic [31:0] res_rdata;
    logic        res_valid;
    logic        busy;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_ren   (req_ren),
        .i_req_addr  (req_addr),
        .o_res_rdata (res_rdata),
        .o_res_valid (res_valid),
        .o_busy      (busy),
        .o_mem_ren   (mem_ren),
        .o_mem_addr  (mem_addr),
        .i_mem_ready (mem_ready),
        .i_mem_valid (mem_valid),
        .i_mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_cnt   (hit_cnt),
        .o_miss_cnt  (miss_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: returns the word address as data; ready and valid delays are tunable.
    int          ready_delay = 0;
    int          valid_delay = 0;
    int          rcnt = 0;
    int          vcnt = 0;
    bit          pending = 0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] held_addr = 32'd0;
    logic [31:0] req_log[$];

    always @(posedge clk) begin
        #1;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        if (pending) begin
            if (vcnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = pend_addr;
                pending   = 0;
            end else begin
                vcnt--;
            end
        end else if (mem_ren) begin
            if (rcnt > 0) check_eq("mem_addr_stable", mem_addr, held_addr);
            held_addr = mem_addr;
            if (rcnt < ready_delay) begin
                rcnt++;
            end else begin
                mem_ready = 1'b1;
                pending   = 1;
                pend_addr = mem_addr;
                vcnt      = valid_delay;
                rcnt      = 0;
                req_log.push_back(mem_addr);
            end
        end
    end

    task automatic wait_hit(input string tag, input int exp_cycles, output int cycles);
        bit got = 0;
        cycles = 0;
        while (!got && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
            if (res_valid) got = 1;
            else check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    endtask

    task automatic miss_fetch(input string tag, input logic [31:0] addr, input int exp_cycles);
        int          cycles;
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        req_log.delete();
        @(negedge clk);
        req_ren  = 1'b1;
        req_addr = addr;
        #1;
        check_eq({tag, "_busy_now"}, 32'(busy), 32'd1);
        check_eq({tag, "_no_valid"}, 32'(res_valid), 32'd0);
        wait_hit(tag, exp_cycles, cycles);
        check_eq({tag, "_rdata"}, res_rdata, addr);
        check_eq({tag, "_nreq"}, 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_log.size()) check_eq({tag, "_req_addr"}, req_log[i], base + 32'(4 * i));
        end
        $display("[tb] miss addr=0x%08h data=0x%08h cycles=%0d", addr, res_rdata, cycles);
    endtask

    task automatic hit_fetch(input string tag, input logic [31:0] addr);
        @(negedge clk);
        req_ren  = 1'b1;
        req_addr = addr;
        #1;
        check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
        check_eq({tag, "_rdata"}, res_rdata, addr);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
        $display("[tb] hit  addr=0x%08h data=0x%08h", addr, res_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        req_ren  = 1'b0;
        req_addr = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_ren", 32'(mem_ren), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_res_rdata", res_rdata, 32'd0);
`ifdef ICACHE_STATS_EN
        check_eq("rst_hit_cnt", hit_cnt, 32'd0);
        check_eq("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        // Cold miss: 1 + 4*(1+1) + 1 cycles to the retried hit.
        miss_fetch("cold", 32'h0000_0040, 10);
`ifdef ICACHE_STATS_EN
        @(posedge clk);
        #1;
        check_eq("stats_hit_cnt", hit_cnt, 32'd1);
        check_eq("stats_miss_cnt", miss_cnt, 32'd1);
`endif
        hit_fetch("hit48", 32'h0000_0048);
`ifdef ICACHE_STATS_EN
        @(posedge clk);
        #1;
        check_eq("stats_hit_cnt2", hit_cnt, 32'd2);
        check_eq("stats_miss_cnt2", miss_cnt, 32'd1);
`endif

        // Same index, different tag evicts and back again.
        miss_fetch("conf_a", 32'h0000_0240, 10);
        miss_fetch("conf_b", 32'h0000_0040, 10);

        // Backpressure: each word takes (5+1) REQ cycles and (3+1) WAIT cycles.
        ready_delay = 5;
        valid_delay = 3;
        miss_fetch("bp", 32'h0000_03F8, 42);
        ready_delay = 0;
        valid_delay = 0;
        hit_fetch("bp_w0", 32'h0000_03F0);
        hit_fetch("bp_w1", 32'h0000_03F4);
        hit_fetch("bp_w3", 32'h0000_03FC);

        // Reset while waiting on word 2; the late response must be ignored.
        req_log.delete();
        valid_delay = 2;
        @(negedge clk);
        req_ren  = 1'b1;
        req_addr = 32'h0000_0080;
        #1;
        check_eq("rstmid_busy", 32'(busy), 32'd1);
        begin
            int guard = 0;
            while (req_log.size() < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_eq("rstmid_reach_word2", 32'(req_log.size()), 32'd3);
        end
        @(negedge clk);
        rst_n   = 1'b0;
        req_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rstmid_mem_ren", 32'(mem_ren), 32'd0);
        check_eq("rstmid_busy_idle", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        valid_delay = 0;
        miss_fetch("refetch", 32'h0000_0080, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
